// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: load-use hazard detection, bubble
// insertion, redirect squash, WB-to-operand bypass and saturating event counters.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rs1_data,
    input  logic [DW-1:0] id_rs2_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic [2:0]    id_funct3,
    input  logic          id_RegWrite,
    input  logic          id_MemWrite,
    input  logic          id_MemRead,
    input  logic          id_ALUSrc,
    input  logic [4:0]    id_ALUOp,
    input  logic [4:0]    id_NPCOp,
    input  logic [1:0]    id_WDSel,
    input  logic          wb_RegWrite,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_wd,
    input  logic          flush_i,
    output logic          stall_o,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_rs1_data,
    output logic [DW-1:0] ex_rs2_data,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_rs1,
    output logic [RW-1:0] ex_rs2,
    output logic [RW-1:0] ex_rd,
    output logic [2:0]    ex_funct3,
    output logic          ex_RegWrite,
    output logic          ex_MemWrite,
    output logic          ex_MemRead,
    output logic          ex_ALUSrc,
    output logic [4:0]    ex_ALUOp,
    output logic [4:0]    ex_NPCOp,
    output logic [1:0]    ex_WDSel,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic          r_ex_valid;
    logic [DW-1:0] r_ex_pc, r_ex_rs1_data, r_ex_rs2_data, r_ex_imm;
    logic [RW-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
    logic [2:0]    r_ex_funct3;
    logic          r_ex_regwrite, r_ex_memwrite, r_ex_memread, r_ex_alusrc;
    logic [4:0]    r_ex_aluop, r_ex_npcop;
    logic [1:0]    r_ex_wdsel;
    logic [CW-1:0] r_stall_cnt, r_flush_cnt;

    logic          w_rs1_match, w_rs2_match, w_hazard, w_bubble;
    logic [DW-1:0] w_rs1_fwd, w_rs2_fwd;

    // Hazard only looks at registered EX state, so a bubble in EX cannot stall.
    assign w_rs1_match = id_use_rs1 && (id_rs1 == r_ex_rd);
    assign w_rs2_match = id_use_rs2 && (id_rs2 == r_ex_rd);
    assign w_hazard    = r_ex_valid && r_ex_memread && (r_ex_rd != '0) && id_valid
                         && (w_rs1_match || w_rs2_match);
    assign stall_o     = w_hazard && !flush_i;
    assign w_bubble    = flush_i || w_hazard || !id_valid;

    assign w_rs1_fwd = (wb_RegWrite && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_wd : id_rs1_data;
    assign w_rs2_fwd = (wb_RegWrite && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_wd : id_rs2_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_funct3   <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_aluop    <= '0;
            r_ex_npcop    <= '0;
            r_ex_wdsel    <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            if (flush_i) begin
                if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else if (w_hazard) begin
                if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end

            // A bubble is a full NOP writing x0, not just a cleared valid bit.
            if (w_bubble) begin
                r_ex_valid    <= 1'b0;
                r_ex_pc       <= '0;
                r_ex_rs1_data <= '0;
                r_ex_rs2_data <= '0;
                r_ex_imm      <= '0;
                r_ex_rs1      <= '0;
                r_ex_rs2      <= '0;
                r_ex_rd       <= '0;
                r_ex_funct3   <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
                r_ex_alusrc   <= 1'b0;
                r_ex_aluop    <= '0;
                r_ex_npcop    <= '0;
                r_ex_wdsel    <= '0;
            end else begin
                r_ex_valid    <= 1'b1;
                r_ex_pc       <= id_pc;
                r_ex_rs1_data <= w_rs1_fwd;
                r_ex_rs2_data <= w_rs2_fwd;
                r_ex_imm      <= id_imm;
                r_ex_rs1      <= id_rs1;
                r_ex_rs2      <= id_rs2;
                r_ex_rd       <= id_rd;
                r_ex_funct3   <= id_funct3;
                r_ex_regwrite <= id_RegWrite;
                r_ex_memwrite <= id_MemWrite;
                r_ex_memread  <= id_MemRead;
                r_ex_alusrc   <= id_ALUSrc;
                r_ex_aluop    <= id_ALUOp;
                r_ex_npcop    <= id_NPCOp;
                r_ex_wdsel    <= id_WDSel;
            end
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_rs1_data = r_ex_rs1_data;
    assign ex_rs2_data = r_ex_rs2_data;
    assign ex_imm      = r_ex_imm;
    assign ex_rs1      = r_ex_rs1;
    assign ex_rs2      = r_ex_rs2;
    assign ex_rd       = r_ex_rd;
    assign ex_funct3   = r_ex_funct3;
    assign ex_RegWrite = r_ex_regwrite;
    assign ex_MemWrite = r_ex_memwrite;
    assign ex_MemRead  = r_ex_memread;
    assign ex_ALUSrc   = r_ex_alusrc;
    assign ex_ALUOp    = r_ex_aluop;
    assign ex_NPCOp    = r_ex_npcop;
    assign ex_WDSel    = r_ex_wdsel;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second narrow-counter instance shares the
// stimulus so counter saturation is reachable in a few dozen cycles.
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rstn;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2;
   logic [2:0]  id_funct3;
   logic        id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc;
   logic [4:0]  id_ALUOp, id_NPCOp;
   logic [1:0]  id_WDSel;
   logic        wb_RegWrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wd;
   logic        flush_i;

   logic        stall_o, ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
   logic [4:0]  ex_ALUOp, ex_NPCOp;
   logic [1:0]  ex_WDSel;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_stall_o, s_ex_valid;
   logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
   logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
   logic [2:0]  s_ex_funct3;
   logic        s_ex_RegWrite, s_ex_MemWrite, s_ex_MemRead, s_ex_ALUSrc;
   logic [4:0]  s_ex_ALUOp, s_ex_NPCOp;
   logic [1:0]  s_ex_WDSel;
   logic [2:0]  s_stall_cnt, s_flush_cnt;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   id_ex_stage u_dut (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct3(id_funct3),
      .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
      .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp), .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_wd(wb_wd), .flush_i(flush_i),
      .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
      .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
      .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   id_ex_stage #(.CW(3)) u_sat (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct3(id_funct3),
      .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
      .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp), .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_wd(wb_wd), .flush_i(flush_i),
      .stall_o(s_stall_o), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
      .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
      .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct3(s_ex_funct3),
      .ex_RegWrite(s_ex_RegWrite), .ex_MemWrite(s_ex_MemWrite), .ex_MemRead(s_ex_MemRead),
      .ex_ALUSrc(s_ex_ALUSrc), .ex_ALUOp(s_ex_ALUOp), .ex_NPCOp(s_ex_NPCOp), .ex_WDSel(s_ex_WDSel),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (!ok) begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id();
      id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      id_funct3 = '0; id_RegWrite = 1'b0; id_MemWrite = 1'b0; id_MemRead = 1'b0;
      id_ALUSrc = 1'b0; id_ALUOp = '0; id_NPCOp = '0; id_WDSel = '0;
   endtask

   // lw xRD, 0(x0)
   task automatic set_load(input logic [31:0] pc, input logic [4:0] rd);
      clear_id();
      id_valid = 1'b1; id_pc = pc; id_rd = rd; id_use_rs1 = 1'b1;
      id_MemRead = 1'b1; id_RegWrite = 1'b1; id_ALUSrc = 1'b1;
      id_WDSel = 2'b01; id_funct3 = 3'b010;
   endtask

   // add xRD, xRS1, xRS2
   task automatic set_add(input logic [31:0] pc, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
      clear_id();
      id_valid = 1'b1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 5'b00011;
   endtask

   initial begin
      clear_id();
      wb_RegWrite = 1'b0; wb_rd = '0; wb_wd = '0; flush_i = 1'b0;
      rstn = 1'b0;
      #12 rstn = 1'b1;
      #1;
      chk("reset_ex_valid", ex_valid === 1'b0, ex_valid, 1'b0);
      chk("reset_stall_cnt", stall_cnt === 16'h0, stall_cnt, 16'h0);
      chk("reset_flush_cnt", flush_cnt === 16'h0, flush_cnt, 16'h0);
      chk("reset_stall_o", stall_o === 1'b0, stall_o, 1'b0);

      set_add(32'h10, 5'd3, 5'd1, 5'd2);
      id_rs1_data = 32'hA; id_rs2_data = 32'hB;
      #1 chk("norm_stall_pre", stall_o === 1'b0, stall_o, 1'b0);
      tick();
      chk("norm_ex_pc", ex_pc === 32'h10, ex_pc, 32'h10);
      chk("norm_ex_rd", ex_rd === 5'd3, ex_rd, 5'd3);
      chk("norm_ex_aluop", ex_ALUOp === 5'b00011, ex_ALUOp, 5'b00011);
      chk("norm_ex_valid", ex_valid === 1'b1, ex_valid, 1'b1);
      chk("norm_ex_regwrite", ex_RegWrite === 1'b1, ex_RegWrite, 1'b1);
      chk("norm_ex_rs1_data", ex_rs1_data === 32'hA, ex_rs1_data, 32'hA);
      chk("norm_ex_rs2_data", ex_rs2_data === 32'hB, ex_rs2_data, 32'hB);
      chk("norm_stall_post", stall_o === 1'b0, stall_o, 1'b0);

      set_load(32'h14, 5'd5);
      tick();
      chk("lu_ex_memread", ex_MemRead === 1'b1, ex_MemRead, 1'b1);
      chk("lu_ex_rd", ex_rd === 5'd5, ex_rd, 5'd5);
      chk("lu_ex_wdsel", ex_WDSel === 2'b01, ex_WDSel, 2'b01);
      chk("lu_ex_funct3", ex_funct3 === 3'b010, ex_funct3, 3'b010);
      set_add(32'h18, 5'd6, 5'd5, 5'd1);
      #1 chk("lu_stall", stall_o === 1'b1, stall_o, 1'b1);
      tick();
      chk("lu_bubble_valid", ex_valid === 1'b0, ex_valid, 1'b0);
      chk("lu_bubble_regwrite", ex_RegWrite === 1'b0, ex_RegWrite, 1'b0);
      chk("lu_bubble_rd", ex_rd === 5'd0, ex_rd, 5'd0);
      chk("lu_bubble_pc", ex_pc === 32'h0, ex_pc, 32'h0);
      chk("lu_stall_drop", stall_o === 1'b0, stall_o, 1'b0);
      chk("lu_stall_cnt", stall_cnt === 16'd1, stall_cnt, 16'd1);
      tick();
      chk("lu_add_valid", ex_valid === 1'b1, ex_valid, 1'b1);
      chk("lu_add_rd", ex_rd === 5'd6, ex_rd, 5'd6);
      chk("lu_add_pc", ex_pc === 32'h18, ex_pc, 32'h18);
      chk("lu_stall_cnt_hold", stall_cnt === 16'd1, stall_cnt, 16'd1);

      set_load(32'h1C, 5'd0);
      tick();
      set_add(32'h20, 5'd6, 5'd0, 5'd0);
      #1 chk("nfs_rd0_stall", stall_o === 1'b0, stall_o, 1'b0);
      tick();
      set_load(32'h24, 5'd5);
      tick();
      set_add(32'h28, 5'd6, 5'd1, 5'd5);
      id_use_rs2 = 1'b0;
      #1 chk("nfs_rs2_unused_stall", stall_o === 1'b0, stall_o, 1'b0);
      tick();
      chk("nfs_valid", ex_valid === 1'b1, ex_valid, 1'b1);
      chk("nfs_pc", ex_pc === 32'h28, ex_pc, 32'h28);
      chk("nfs_stall_cnt", stall_cnt === 16'd1, stall_cnt, 16'd1);

      set_load(32'h2C, 5'd5);
      tick();
      set_add(32'h30, 5'd6, 5'd5, 5'd1);
      flush_i = 1'b1;
      #1 chk("fl_stall", stall_o === 1'b0, stall_o, 1'b0);
      tick();
      flush_i = 1'b0;
      chk("fl_bubble_valid", ex_valid === 1'b0, ex_valid, 1'b0);
      chk("fl_flush_cnt", flush_cnt === 16'd1, flush_cnt, 16'd1);
      chk("fl_stall_cnt", stall_cnt === 16'd1, stall_cnt, 16'd1);
      tick();
      chk("fl_next_pc", ex_pc === 32'h30, ex_pc, 32'h30);

      set_add(32'h40, 5'd9, 5'd7, 5'd8);
      id_rs1_data = 32'h1111_1111; id_rs2_data = 32'h2222_2222;
      wb_RegWrite = 1'b1; wb_rd = 5'd7; wb_wd = 32'hDEAD_BEEF;
      tick();
      chk("byp_rs1", ex_rs1_data === 32'hDEAD_BEEF, ex_rs1_data, 32'hDEAD_BEEF);
      chk("byp_rs2_untouched", ex_rs2_data === 32'h2222_2222, ex_rs2_data, 32'h2222_2222);
      id_rs1 = 5'd0; id_rs1_data = 32'h3333_3333; wb_rd = 5'd0;
      tick();
      chk("byp_x0_rs1", ex_rs1_data === 32'h3333_3333, ex_rs1_data, 32'h3333_3333);
      id_rs1 = 5'd7; id_rs1_data = 32'h1111_1111; id_rs2 = 5'd9; wb_rd = 5'd9;
      tick();
      chk("byp_rs2", ex_rs2_data === 32'hDEAD_BEEF, ex_rs2_data, 32'hDEAD_BEEF);
      chk("byp_rs1_nomatch", ex_rs1_data === 32'h1111_1111, ex_rs1_data, 32'h1111_1111);
      wb_RegWrite = 1'b0;
      tick();
      chk("byp_no_regwrite", ex_rs2_data === 32'h2222_2222, ex_rs2_data, 32'h2222_2222);
      id_valid = 1'b0;
      tick();
      chk("invalid_bubble", ex_valid === 1'b0, ex_valid, 1'b0);
      chk("invalid_stall_cnt", stall_cnt === 16'd1, stall_cnt, 16'd1);
      chk("invalid_flush_cnt", flush_cnt === 16'd1, flush_cnt, 16'd1);

      for (int i = 0; i < 9; i++) begin
         set_load(32'h100, 5'd4);
         tick();
         set_add(32'h104, 5'd6, 5'd1, 5'd4);
         #1 chk("sat_stall", stall_o === 1'b1, stall_o, 1'b1);
         tick();
         tick();
      end
      chk("sat_stall_cnt_wide", stall_cnt === 16'd10, stall_cnt, 16'd10);
      chk("sat_stall_cnt_narrow", s_stall_cnt === 3'd7, s_stall_cnt, 3'd7);
      flush_i = 1'b1;
      repeat (8) tick();
      flush_i = 1'b0;
      chk("sat_flush_cnt_wide", flush_cnt === 16'd9, flush_cnt, 16'd9);
      chk("sat_flush_cnt_narrow", s_flush_cnt === 3'd7, s_flush_cnt, 3'd7);

      set_load(32'h200, 5'd5);
      tick();
      set_add(32'h204, 5'd6, 5'd5, 5'd1);
      #1 chk("rst_pre_stall", stall_o === 1'b1, stall_o, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk("rst_ex_valid", ex_valid === 1'b0, ex_valid, 1'b0);
      chk("rst_ex_memread", ex_MemRead === 1'b0, ex_MemRead, 1'b0);
      chk("rst_ex_rd", ex_rd === 5'd0, ex_rd, 5'd0);
      chk("rst_ex_pc", ex_pc === 32'h0, ex_pc, 32'h0);
      chk("rst_stall_o", stall_o === 1'b0, stall_o, 1'b0);
      chk("rst_stall_cnt", stall_cnt === 16'h0, stall_cnt, 16'h0);
      chk("rst_flush_cnt", flush_cnt === 16'h0, flush_cnt, 16'h0);
      #3 rstn = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage RV32I core.
- Registers the decode-stage control word (RegWrite, MemWrite, MemRead, ALUOp, NPCOp, ALUSrc, WDSel) together with operands, immediate, PC and register indices, and presents them to EX.
- Detects load-use hazards, stalls PC/IF-ID and inserts a bubble. Squashes the decode instruction on an EX redirect.
- Bypasses a same-cycle WB write into the captured operands.

Parameters:
- DW, 32, datapath width (PC, operands, immediate)
- RW, 5, register index width
- CW, 16, width of the saturating performance counters

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  DW  PC of decode instruction
- id_rs1_data, id_rs2_data  in  DW  register-file read data
- id_imm  in  DW  extended immediate
- id_rs1, id_rs2, id_rd  in  RW  register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_funct3  in  3  funct3, passed to EX for branch/load-store width
- id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc  in  1  decoder controls
- id_ALUOp  in  5  decoder ALU op
- id_NPCOp  in  5  decoder next-PC op
- id_WDSel  in  2  decoder writeback select
- wb_RegWrite  in  1  WB stage writing register file
- wb_rd  in  RW  WB destination
- wb_wd  in  DW  WB write data
- flush_i  in  1  EX redirect (taken branch/jal/jalr); squash decode slot
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX slot valid
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  DW  registered copies
- ex_rs1, ex_rs2, ex_rd  out  RW  registered indices
- ex_funct3  out  3  registered funct3
- ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc  out  1  registered controls
- ex_ALUOp, ex_NPCOp  out  5  registered controls
- ex_WDSel  out  2  registered control
- stall_cnt, flush_cnt  out  CW  saturating event counters

Behaviour:
- Reset (rstn low, asynchronous): every ex_* output and both counters are 0; ex_valid is 0. stall_o is combinational and equals 0 while ex_valid is 0.
- Hazard definition:
  - hazard = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - stall_o = hazard & ~flush_i. It is combinational, with no added latency.
- Next-state priority at each clk edge:
  1. flush_i = 1: load a bubble. flush_cnt increments.
  2. hazard = 1: load a bubble. stall_cnt increments. Upstream holds, so the same instruction is re-presented next cycle.
  3. id_valid = 0: load a bubble. No counter changes.
  4. Otherwise: capture all id_* fields and set ex_valid = 1.
- Bubble contents: ex_valid = 0; ex_RegWrite, ex_MemWrite and ex_MemRead are 0; ex_NPCOp, ex_ALUOp and ex_WDSel are 0; ex_ALUSrc = 0. All data and index fields are also 0, so a bubble is a NOP with rd = x0.
- Load-use stall length is exactly one cycle: the bubble clears ex_MemRead, so hazard drops on the following cycle.
- WB bypass, applied at capture time:
  - If wb_RegWrite & wb_rd != 0 & wb_rd == id_rs1, then ex_rs1_data <= wb_wd; otherwise ex_rs1_data <= id_rs1_data. rs2 uses the same rule independently.
  - x0 is never bypassed.
- Latency: ID to EX is 1 cycle. No combinational path from id_* to ex_*.
- Counters:
  - Increment by 1 per event cycle and saturate at 2^CW − 1 (no wrap).
  - stall_cnt counts hazard cycles that are not flushed.
- Simultaneous flush_i and hazard: the flush wins, stall_o = 0, and only flush_cnt increments.
- Reset asserted mid-stall: outputs clear immediately and stall_o falls to 0 in the same cycle.

Test Plan:
1. Reset mid-run: assert rstn = 0 while ex_valid = 1 and ex_MemRead = 1 -> all ex_* outputs, counters and stall_o go to 0 asynchronously, before the next clk edge.
2. Normal flow: add x3,x1,x2 at id_pc = 0x0000_0010 with ALUOp = 5'b00011, RegWrite = 1 -> one cycle later ex_pc = 0x10, ex_rd = 3, ex_ALUOp = 5'b00011, ex_valid = 1, stall_o = 0 throughout.
3. Load-use:
   - Stimulus: lw x5,0(x0) in EX (ex_MemRead = 1, ex_rd = 5), then add x6,x5,x1 in ID with id_use_rs1 = 1.
   - Response: stall_o = 1 for exactly one cycle. The next EX slot is a bubble (ex_valid = 0, ex_RegWrite = 0). The add then captures on the following edge with stall_o = 0, and stall_cnt = 1.
4. No false stall: same as scenario 3 but ex_rd = 0, or id_use_rs2 = 0 with only rs2 matching -> stall_o stays 0 and stall_cnt stays 0.
5. Flush priority: flush_i = 1 in the same cycle as a load-use hazard -> stall_o = 0, EX slot becomes a bubble, flush_cnt = 1, stall_cnt = 0.
6. WB bypass:
   - Stimulus: id_rs1 = 7, id_rs1_data = 0x1111_1111, wb_RegWrite = 1, wb_rd = 7, wb_wd = 0xDEAD_BEEF -> ex_rs1_data = 0xDEAD_BEEF.
   - Repeat with wb_rd = 0 and id_rs1 = 0 -> ex_rs1_data = id_rs1_data.
   - Saturation: force CW stall events past 0xFFFF -> stall_cnt holds at 0xFFFF.
